// File: rtl/match_seq_det.sv
// Serial pattern detector: compares a configurable-length bit pattern against
// the incoming stream, with overlap/non-overlap modes and a saturating match counter.
module match_seq_det #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 16,
  localparam int LW      = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_cnt,
  output logic               z,
  output logic               z_q,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [31:0]      RST_PAT   = 32'h0000_0006;
  localparam int               RST_LEN_I = (MAX_LEN < 4) ? MAX_LEN : 4;
  localparam logic [LW-1:0]    RST_LEN   = LW'(RST_LEN_I);
  localparam logic [LW-1:0]    MAX_L     = LW'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] hist_r;
  logic [LW-1:0]      fill_r;
  logic [MAX_LEN-1:0] pattern_r;
  logic [LW-1:0]      len_r;
  logic               overlap_r;
  logic               z_q_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [MAX_LEN-1:0] mask_s;
  logic [MAX_LEN-1:0] window_s;
  logic               fill_ok_s;
  logic               z_s;
  logic [LW-1:0]      load_len_s;

  // Low-len-bit mask and the candidate window {hist, x} restricted to MAX_LEN bits
  always_comb begin
    mask_s   = '0;
    window_s = {hist_r[MAX_LEN-2:0], x};
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) < len_r) begin
        mask_s[i] = 1'b1;
      end else begin
        mask_s[i] = 1'b0;
      end
    end
  end

  // Mealy match decision; only stored configuration feeds it, never cfg_pattern/len/overlap
  always_comb begin
    fill_ok_s = (fill_r >= (len_r - LW'(1)));
    if (rst || !en || cfg_load || (len_r == '0)) begin
      z_s = 1'b0;
    end else if (fill_ok_s && ((window_s & mask_s) == (pattern_r & mask_s))) begin
      z_s = 1'b1;
    end else begin
      z_s = 1'b0;
    end
  end

  // Clamp an oversized requested length to MAX_LEN
  always_comb begin
    if (cfg_len > MAX_L) begin
      load_len_s = MAX_L;
    end else begin
      load_len_s = cfg_len;
    end
  end

  assign z         = z_s;
  assign z_q       = z_q_r;
  assign match_cnt = cnt_r;

  // Configuration, history and fill tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_r    <= '0;
      fill_r    <= '0;
      pattern_r <= RST_PAT[MAX_LEN-1:0];
      len_r     <= RST_LEN;
      overlap_r <= 1'b1;
    end else if (cfg_load) begin
      pattern_r <= cfg_pattern;
      len_r     <= load_len_s;
      overlap_r <= cfg_overlap;
      fill_r    <= '0;
    end else if (en) begin
      hist_r <= {hist_r[MAX_LEN-2:0], x};
      // Non-overlap restarts the valid-bit count so no matched bit is reused
      if (z_s && !overlap_r) begin
        fill_r <= '0;
      end else if (fill_r != MAX_L) begin
        fill_r <= fill_r + LW'(1);
      end else begin
        fill_r <= fill_r;
      end
    end else begin
      hist_r <= hist_r;
      fill_r <= fill_r;
    end
  end

  // Delayed match pulse and saturating match counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q_r <= 1'b0;
      cnt_r <= '0;
    end else begin
      z_q_r <= z_s;
      if (clr_cnt) begin
        cnt_r <= '0;
      end else if (z_s && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_match_seq_det.sv
// Self-checking bench for match_seq_det: directed scenarios plus randomized traffic
// against a queue-based reference model; a CNT_W=2 instance shares all stimulus.
module tb_match_seq_det;

  localparam int MAX_LEN = 8;
  localparam int LW      = $clog2(MAX_LEN) + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en = 1'b0;
  logic               x = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LW-1:0]      cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               clr_cnt = 1'b0;
  logic               z_a, zq_a, z_b, zq_b;
  logic [15:0]        cnt_a;
  logic [1:0]         cnt_b;

  int tests = 0;
  int fails = 0;

  // Reference model: list of valid history bits, oldest first
  bit          q[$];
  logic [7:0]  m_pat;
  int          m_len;
  bit          m_ov;
  int          m_cnt16, m_cnt2;
  bit          m_zq;
  bit          ez;

  match_seq_det #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .en(en), .x(x), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clr_cnt(clr_cnt), .z(z_a), .z_q(zq_a), .match_cnt(cnt_a));

  match_seq_det #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .x(x), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clr_cnt(clr_cnt), .z(z_b), .z_q(zq_b), .match_cnt(cnt_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_z(input bit e, input bit xb, input bit ld);
    if (!e || ld || m_len == 0) return 1'b0;
    if (q.size() + 1 < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      bit b;
      b = (k == 0) ? xb : q[q.size() - k];
      if (b != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pat = 8'b0000_0110; m_len = 4; m_ov = 1'b1;
    m_cnt16 = 0; m_cnt2 = 0; m_zq = 1'b0;
  endtask

  // One clock: drive at negedge, check z before the edge, z_q/count after it
  task automatic cyc(input bit e, input bit xb, input bit ld, input bit cl);
    @(negedge clk);
    en = e; x = xb; cfg_load = ld; clr_cnt = cl;
    #1;
    ez = model_z(e, xb, ld);
    chk("z", {31'd0, z_a}, {31'd0, ez});
    chk("z_w2", {31'd0, z_b}, {31'd0, ez});
    if (ld) begin
      m_pat = cfg_pattern;
      m_len = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
      m_ov  = cfg_overlap;
      q.delete();
    end else if (e) begin
      if (ez && !m_ov) q.delete();
      else begin
        q.push_back(xb);
        if (q.size() > MAX_LEN) void'(q.pop_front());
      end
    end
    if (cl) begin
      m_cnt16 = 0; m_cnt2 = 0;
    end else if (ez) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    m_zq = ez;
    @(posedge clk);
    #1;
    chk("z_q", {31'd0, zq_a}, {31'd0, m_zq});
    chk("cnt", {16'd0, cnt_a}, m_cnt16);
    chk("cnt_w2", {30'd0, cnt_b}, m_cnt2);
  endtask

  task automatic load(input logic [7:0] pat, input logic [LW-1:0] len, input bit ov);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
    cyc(1'b1, 1'($urandom_range(1)), 1'b1, 1'b0);
  endtask

  task automatic feed(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) cyc(1'b1, bits[i], 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse away from any clock edge
  task automatic do_reset();
    @(negedge clk);
    en = 1'b1; x = 1'b1; cfg_load = 1'b0; clr_cnt = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_z", {31'd0, z_a}, 32'd0);
    chk("rst_zq", {31'd0, zq_a}, 32'd0);
    chk("rst_cnt", {16'd0, cnt_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Defaults, overlapping 0110 on 0110110
    feed(8'b0011_0110, 7);
    chk("dir_cnt_ovl", {16'd0, cnt_a}, 32'd2);

    // Non-overlapping 0110 on the same stream
    load(8'b0000_0110, 4'd4, 1'b0);
    feed(8'b0011_0110, 7);
    chk("dir_cnt_novl", {16'd0, cnt_a}, 32'd3);

    // 8-bit pattern across a 3-cycle stall
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    load(8'b1011_0011, 4'd8, 1'b1);
    feed(8'b0000_1011, 4);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'($urandom_range(1)), 1'b0, 1'b0);
    feed(8'b0000_0011, 4);
    chk("dir_cnt_stall", {16'd0, cnt_a}, 32'd1);

    // Pattern 11: saturation of the narrow counter, then clear against a match
    load(8'b0000_0011, 4'd2, 1'b1);
    feed(8'b0011_1111, 6);
    chk("dir_sat", {30'd0, cnt_b}, 32'd3);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("dir_clr", {30'd0, cnt_b}, 32'd0);

    // Reset mid-pattern discards progress
    do_reset();
    feed(8'b0000_0011, 3);
    do_reset();
    feed(8'b0000_0000, 1);
    feed(8'b0000_0110, 4);
    chk("dir_rst_mid", {16'd0, cnt_a}, 32'd1);

    // len=0 disables detection, oversized len clamps
    load(8'($urandom), 4'd0, 1'b1);
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
    load(8'b1010_0101, 4'(MAX_LEN + 3), 1'b1);
    feed(8'b1010_0101, 8);
    feed(8'b1010_0101, 8);

    // Randomized traffic with occasional reconfiguration and clears
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(99));
      if (r < 3) begin
        cfg_pattern = 8'($urandom);
        cfg_len     = LW'($urandom_range(5));
        cfg_overlap = 1'($urandom_range(1));
        cyc(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, 1'b0);
      end else begin
        cyc(r < 85, 1'($urandom_range(1)), 1'b0, r > 97);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
